fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly downstream of pc: consumes PcAddr, fetches
//  from a variable-latency instruction memory (MemRd/MemDone handshake), and
//  loads the IF/ID register (Instr, PcPlus2, InstrValid) that feeds decode.
//  Drives PcHold back into pc's Halt input so PC advances once per accepted
//  instruction. Handles decode stall (skid buffer), redirect flush and HALT.
// PARAMETERS
//  WIDTH        16        data/address width
//  HALT_OPCODE  5'b00000  Instr[15:11] value that stops fetch
//  NOP_INSTR    16'h0800  value loaded into Instr on reset/flush/bubble
// PORTS
//  clk         in   1      clock
//  rst         in   1      async reset, active-low (0 = reset)
//  PcAddr      in   WIDTH  current PC from pc
//  Stall       in   1      decode cannot accept; IF/ID must hold
//  Flush       in   1      redirect (branch/jump) this cycle; kill in-flight fetch
//  MemRdata    in   WIDTH  instruction memory read data, valid with MemDone
//  MemDone     in   1      memory completes request this cycle
//  MemAddr     out  WIDTH  registered request address (ReqAddr)
//  MemRd       out  1      read request, held until MemDone
//  Instr       out  WIDTH  IF/ID instruction
//  PcPlus2     out  WIDTH  IF/ID fetch address + 2 (mod 2^WIDTH)
//  InstrValid  out  1      IF/ID holds a real instruction
//  PcHold      out  1      to pc Halt; 0 = PC updates at this edge
//  Halted      out  1      HALT fetched; fetch stopped
// BEHAVIOUR
//  Reset (rst=0, async): state=ISSUE, ReqAddr=0, Instr=NOP_INSTR, PcPlus2=0,
//   InstrValid=0, Skid=0, Halted=0. MemRd/PcHold are state-decoded (0/1 in ISSUE).
//  States: ISSUE, WAIT, HOLD, DRAIN, HALTED. MemRd=1 only in WAIT/DRAIN.
//  ISSUE: ReqAddr<=PcAddr; ->WAIT. PcHold=1 unless Flush (then ->ISSUE, PC redirects).
//  WAIT (MemAddr=ReqAddr stable), priority top-down:
//   Flush & !MemDone -> DRAIN; Flush & MemDone -> discard, ->ISSUE; PcHold=0.
//   MemDone & Stall  -> Skid<=MemRdata, ->HOLD; PcHold=1.
//   MemDone & !Stall -> Instr<=MemRdata, PcPlus2<=ReqAddr+2, InstrValid<=1,
//     PcHold=0; ->HALTED if opcode==HALT_OPCODE (Halted<=1) else ->ISSUE.
//   no MemDone       -> stay; PcHold=1.
//  HOLD: PcHold=1 while Stall. !Stall: IF/ID<=Skid, InstrValid<=1, PcHold=0,
//   ->HALTED if Skid is HALT else ->ISSUE. Flush: drop Skid, PcHold=0, ->ISSUE.
//  DRAIN: MemRd=1, PcHold=1 until MemDone; data discarded; ->ISSUE.
//  HALTED: MemRd=0, PcHold=1 until reset; Flush (speculative HALT) clears
//   Halted, PcHold=0, ->ISSUE.
//  IF/ID: Flush => Instr=NOP_INSTR, InstrValid=0 (overrides Stall). Stall
//   without capture => hold all. No Stall, no capture => InstrValid=0, Instr=NOP.
//  PcPlus2 wraps: ReqAddr=16'hFFFE -> 16'h0000. Min throughput 1 instr / 2 cycles.
//  Reset mid-request: MemRd drops immediately; memory must tolerate abandonment.
// TESTING
//  1 Reset low 2 cycles, MemDone=1 always, PC from pc -> Instr seq at PcAddr 0,2,4,
//    InstrValid pulses every 2nd cycle, PcHold=0 only on accept cycles.
//  2 MemDone delayed 3 cycles -> MemRd/MemAddr stable 3 cycles, PcHold=1 throughout.
//  3 Stall=1 at MemDone with data 16'hA123 -> Skid holds, IF/ID unchanged; Stall=0
//    -> Instr=16'hA123, InstrValid=1, PC advances by exactly 2 once.
//  4 Flush in WAIT cycle 1 (MemDone 2 cycles later) -> DRAIN, response dropped,
//    Instr=NOP, InstrValid=0, next MemAddr = redirect target.
//  5 Fetch 16'h0000 -> Halted=1, MemRd=0, PcHold=1 for 20 cycles; then Flush -> resume.
//  6 ReqAddr=16'hFFFE accepted -> PcPlus2=16'h0000; async rst mid-WAIT -> MemRd=0 at once.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC -> variable-latency imem -> IF/ID register, with skid, flush and HALT.
// Min 2 cycles per instruction; decode Stall parks a completed fetch in the skid register and holds PC.
module fetch_unit #(
   parameter int                 WIDTH       = 16,
   parameter logic [4:0]         HALT_OPCODE = 5'b00000,
   parameter logic [WIDTH-1:0]   NOP_INSTR   = 16'h0800
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] PcAddr,
   input  logic             Stall,
   input  logic             Flush,
   input  logic [WIDTH-1:0] MemRdata,
   input  logic             MemDone,
   output logic [WIDTH-1:0] MemAddr,
   output logic             MemRd,
   output logic [WIDTH-1:0] Instr,
   output logic [WIDTH-1:0] PcPlus2,
   output logic             InstrValid,
   output logic             PcHold,
   output logic             Halted
);

   typedef enum logic [2:0] {
      S_ISSUE  = 3'd0,
      S_WAIT   = 3'd1,
      S_HOLD   = 3'd2,
      S_DRAIN  = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] req_addr;
   logic [WIDTH-1:0] skid;
   logic             load_req, load_skid, cap_mem, cap_skid, set_halt, clr_halt;
   logic             mem_is_halt, skid_is_halt;

   assign mem_is_halt  = (MemRdata[WIDTH-1 -: 5] == HALT_OPCODE);
   assign skid_is_halt = (skid[WIDTH-1 -: 5] == HALT_OPCODE);
   assign MemAddr      = req_addr;

   always_comb begin
      state_nxt = state;
      PcHold    = 1'b1;
      MemRd     = 1'b0;
      load_req  = 1'b0;
      load_skid = 1'b0;
      cap_mem   = 1'b0;
      cap_skid  = 1'b0;
      set_halt  = 1'b0;
      clr_halt  = 1'b0;
      case (state)
         S_ISSUE: begin
            if (Flush) begin
               PcHold = 1'b0;
            end else begin
               load_req  = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            MemRd = 1'b1;
            if (Flush) begin
               PcHold    = 1'b0;
               state_nxt = MemDone ? S_ISSUE : S_DRAIN;
            end else if (MemDone && Stall) begin
               load_skid = 1'b1;
               state_nxt = S_HOLD;
            end else if (MemDone) begin
               cap_mem   = 1'b1;
               PcHold    = 1'b0;
               set_halt  = mem_is_halt;
               state_nxt = mem_is_halt ? S_HALTED : S_ISSUE;
            end
         end
         S_HOLD: begin
            if (Flush) begin
               PcHold    = 1'b0;
               state_nxt = S_ISSUE;
            end else if (!Stall) begin
               cap_skid  = 1'b1;
               PcHold    = 1'b0;
               set_halt  = skid_is_halt;
               state_nxt = skid_is_halt ? S_HALTED : S_ISSUE;
            end
         end
         S_DRAIN: begin
            // Abandoned request must still complete before a new address is issued.
            MemRd = 1'b1;
            if (MemDone) state_nxt = S_ISSUE;
         end
         S_HALTED: begin
            if (Flush) begin
               clr_halt  = 1'b1;
               PcHold    = 1'b0;
               state_nxt = S_ISSUE;
            end
         end
         default: state_nxt = S_ISSUE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_ISSUE;
         req_addr <= '0;
         skid     <= '0;
         Halted   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_req)  req_addr <= PcAddr;
         if (load_skid) skid     <= MemRdata;
         if (set_halt)      Halted <= 1'b1;
         else if (clr_halt) Halted <= 1'b0;
      end
   end

   // Flush beats Stall; an idle, unstalled cycle inserts a bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Instr      <= NOP_INSTR;
         PcPlus2    <= '0;
         InstrValid <= 1'b0;
      end else if (Flush) begin
         Instr      <= NOP_INSTR;
         InstrValid <= 1'b0;
      end else if (cap_mem) begin
         Instr      <= MemRdata;
         PcPlus2    <= req_addr + WIDTH'(2);
         InstrValid <= 1'b1;
      end else if (cap_skid) begin
         Instr      <= skid;
         PcPlus2    <= req_addr + WIDTH'(2);
         InstrValid <= 1'b1;
      end else if (!Stall) begin
         Instr      <= NOP_INSTR;
         InstrValid <= 1'b0;
      end
   end

endmodule
